// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that hands one requester at a time a byte slot on a shared UART transmitter.
// Handshake: grant, one load strobe, wait for busy (bounded), wait for idle, then an optional idle gap.
module uart_tx_arbiter #(
    parameter int NREQ        = 4,
    parameter int GAP         = 16,
    parameter int ACK_TIMEOUT = 64   // must be at least 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arb_en,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [NREQ-1:0]   err,
    output logic              tx_en,
    output logic              tx_wr,
    output logic [7:0]        tx_data,
    input  logic              tx_busy
);

    // state | meaning
    // IDLE  | waiting for an enabled request while the transmitter is free
    // GRANT | winner latched, gnt and tx_data registered
    // LOAD  | tx_wr strobe asserted for one cycle
    // ACK   | waiting for tx_busy, bounded by ACK_TIMEOUT
    // SEND  | frame on the line, waiting for tx_busy to fall
    // GAP   | GAP idle cycles before the next arbitration
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_LOAD  = 3'd2,
        S_ACK   = 3'd3,
        S_SEND  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    localparam int TW = $clog2(ACK_TIMEOUT);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    state_t            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        win_q, win_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [NREQ-1:0]   err_q, err_d;
    logic              tx_en_q, tx_en_d;
    logic              tx_wr_q, tx_wr_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [GW-1:0]     gap_cnt_q, gap_cnt_d;

    logic              found;
    logic [1:0]        pick;
    logic [1:0]        idx;
    logic              frame_end;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            win_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= '0;
            tx_en_q   <= 1'b0;
            tx_wr_q   <= 1'b0;
            tx_data_q <= '0;
            timer_q   <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            tx_en_q   <= tx_en_d;
            tx_wr_q   <= tx_wr_d;
            tx_data_q <= tx_data_d;
            timer_q   <= timer_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Rotating search: first active request at or after ptr.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        err_d     = '0;
        tx_wr_d   = 1'b0;
        tx_data_d = tx_data_q;
        timer_d   = timer_q;
        gap_cnt_d = gap_cnt_q;
        frame_end = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arb_en && found && !tx_busy) begin
                    state_d     = S_GRANT;
                    win_d       = pick;
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    tx_data_d   = req_data[{pick, 3'b000} +: 8];
                end
            end
            S_GRANT: begin
                state_d = S_LOAD;
                tx_wr_d = 1'b1;
            end
            S_LOAD: begin
                state_d = S_ACK;
                timer_d = '0;
            end
            S_ACK: begin
                if (tx_busy) begin
                    state_d = S_SEND;
                end else if (timer_q == TW'(ACK_TIMEOUT - 2)) begin
                    // err lands exactly ACK_TIMEOUT cycles after the tx_wr cycle
                    err_d[win_q] = 1'b1;
                    frame_end    = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_SEND: begin
                if (!tx_busy) begin
                    done_d[win_q] = 1'b1;
                    frame_end     = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GW'(GAP - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (frame_end) begin
            gnt_d     = '0;
            ptr_d     = win_q + 2'd1;
            gap_cnt_d = '0;
            state_d   = (GAP == 0) ? S_IDLE : S_GAP;
        end

        tx_en_d = arb_en || (state_d == S_GRANT) || (state_d == S_LOAD) ||
                  (state_d == S_ACK) || (state_d == S_SEND);
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign err     = err_q;
    assign tx_en   = tx_en_q;
    assign tx_wr   = tx_wr_q;
    assign tx_data = tx_data_q;

endmodule
